// File: rtl/reg_file_mp_pkg.sv
// Shared processor package: default register-file geometry, read-port limits
// and helpers used to locate one port's slice inside a flattened port bus.
package reg_file_mp_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_RD   = 2;
    localparam int NUM_RD_MIN   = 1;
    localparam int NUM_RD_MAX   = 4;
    localparam int DEF_ZERO_REG = 1;
    localparam int NUM_WR       = 2;

    // Lowest bit of port 'port' in a bus made of 'width'-bit slices.
    function automatic int port_lo(input int port, input int width);
        return port * width;
    endfunction

    // True when the requested number of read ports is supported.
    function automatic bit num_rd_ok(input int n);
        return (n >= NUM_RD_MIN) && (n <= NUM_RD_MAX);
    endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One read port: forwards same-cycle writes/reserves onto the addressed entry
// Latency: 1 cycle, data and pending flag registered together
// No backpressure: a new address is accepted every cycle
module reg_file_rd_port
    import reg_file_mp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          mem_dat,
    input  logic                       pend_cur,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic                       resv_en,
    input  logic [ADDR_W-1:0]          resv_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_pend
);

    logic [DATA_W-1:0] dat_nxt;
    logic              pend_nxt;

    // Post-edge view of the entry: higher write port overrides lower, a reserve overrides any write clear.
    always_comb begin
        dat_nxt  = mem_dat;
        pend_nxt = pend_cur;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p] && (wr_addr[port_lo(p, ADDR_W) +: ADDR_W] == addr)) begin
                dat_nxt  = wr_data[port_lo(p, DATA_W) +: DATA_W];
                pend_nxt = 1'b0;
            end
        end
        if (resv_en && (resv_addr == addr)) begin
            pend_nxt = 1'b1;
        end
    end

    // Output register; reset clears both data and pending flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
            rd_pend <= 1'b0;
        end else begin
            rd_data <= dat_nxt;
            rd_pend <= pend_nxt;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: 2 write ports, NUM_RD read ports, per-entry pending (scoreboard) bits
// Latency: 1 cycle from read address to rd_data/rd_pend, with write-through bypass
// No backpressure: all ports accept every cycle; write port 1 wins on address collision
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = DEF_ZERO_REG
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       resv_en,
    input  logic [ADDR_W-1:0]          resv_addr,
    output logic [NUM_RD-1:0]          rd_pend
);

    localparam int DEPTH = 1 << ADDR_W;

    if (!num_rd_ok(NUM_RD)) begin : g_bad_num_rd
        $error("reg_file_mp: NUM_RD must be 1..4");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [NUM_WR-1:0] we;
    logic [ADDR_W-1:0] wa [NUM_WR];
    logic [DATA_W-1:0] wd [NUM_WR];
    logic              resv_ok;

    // Qualify writes/reserves: with a hardwired zero register, address 0 is never written or reserved.
    always_comb begin
        for (int p = 0; p < NUM_WR; p++) begin
            wa[p] = wr_addr[port_lo(p, ADDR_W) +: ADDR_W];
            wd[p] = wr_data[port_lo(p, DATA_W) +: DATA_W];
            we[p] = wr_en[p] && !((ZERO_REG != 0) && (wa[p] == '0));
        end
        resv_ok = resv_en && !((ZERO_REG != 0) && (resv_addr == '0));
    end

    // Storage: reset loads each entry with its own index; port 1 written last so it wins a collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_W'(i);
            end
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (we[p]) begin
                    mem[wa[p]] <= wd[p];
                end
            end
        end
    end

    // Pending bits: writes clear, a reserve sets afterwards so a new producer wins over the retiring one.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (we[p]) begin
                    pending[wa[p]] <= 1'b0;
                end
            end
            if (resv_ok) begin
                pending[resv_addr] <= 1'b1;
            end
        end
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = rd_addr[port_lo(r, ADDR_W) +: ADDR_W];

        reg_file_rd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rd_port (
            .clk       (clk),
            .reset     (reset),
            .addr      (ra),
            .mem_dat   (mem[ra]),
            .pend_cur  (pending[ra]),
            .wr_en     (we),
            .wr_addr   ({wa[1], wa[0]}),
            .wr_data   ({wd[1], wd[0]}),
            .resv_en   (resv_ok),
            .resv_addr (resv_addr),
            .rd_data   (rd_data[port_lo(r, DATA_W) +: DATA_W]),
            .rd_pend   (rd_pend[r])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp (defaults: 32-bit data, 32 entries, 2 read ports, zero register).
// Inputs change on the falling edge; outputs are checked on the following falling edge.
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int DEPTH = 32;

    logic           clk;
    logic           reset;
    logic [1:0]     wr_en;
    logic [2*AW-1:0] wr_addr;
    logic [2*DW-1:0] wr_data;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic           resv_en;
    logic [AW-1:0]  resv_addr;
    logic [NR-1:0]  rd_pend;

    int n_vec;
    int n_err;

    // Reference model: architectural register contents and pending set.
    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_pend [DEPTH];
    logic [DW-1:0] e_dat  [NR];
    bit            e_pend [NR];

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .resv_en   (resv_en),
        .resv_addr (resv_addr),
        .rd_pend   (rd_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [AW-1:0] wa(input int p);
        return wr_addr[p*AW +: AW];
    endfunction

    function automatic logic [AW-1:0] ra(input int r);
        return rd_addr[r*AW +: AW];
    endfunction

    // Advance one clock; the model applies the architectural rules to the sampled inputs,
    // then the expected outputs are simply the new contents of the addressed registers.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i]  = DW'(i);
                m_pend[i] = 1'b0;
            end
            for (int r = 0; r < NR; r++) begin
                e_dat[r]  = '0;
                e_pend[r] = 1'b0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (wr_en[p] && wa(p) != 0) begin
                    m_mem[wa(p)]  = wr_data[p*DW +: DW];
                    m_pend[wa(p)] = 1'b0;
                end
            end
            if (resv_en && resv_addr != 0) m_pend[resv_addr] = 1'b1;
            for (int r = 0; r < NR; r++) begin
                e_dat[r]  = m_mem[ra(r)];
                e_pend[r] = m_pend[ra(r)];
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        reset   = 1'b0;
        wr_en   = 2'b00;
        resv_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; wr_en = 2'b00; resv_en = 1'b0;
        wr_addr = '0; wr_data = '0; resv_addr = '0; rd_addr = '0;
        tick();
        n_vec++;
        if (rd_data !== '0 || rd_pend !== '0) begin
            n_err++;
            $display("FAIL reset_out: rd_data=%h rd_pend=%b, expected 0/0", rd_data, rd_pend);
        end
        idle();
        rd_addr = {5'd8, 5'd6};
        tick();
        n_vec++;
        if (rd_data !== {32'd8, 32'd6} || rd_pend !== 2'b00) begin
            n_err++;
            $display("FAIL reset_values: rd_data=%h rd_pend=%b, expected %h/00", rd_data, rd_pend, {32'd8, 32'd6});
        end
    endtask

    task automatic test_write_bypass();
        idle();
        wr_en = 2'b01;
        wr_addr[0*AW +: AW] = 5'd4;
        wr_data[0*DW +: DW] = 32'd31;
        rd_addr = {5'd4, 5'd4};
        tick();
        for (int r = 0; r < NR; r++) begin
            n_vec++;
            if (rd_data[r*DW +: DW] !== 32'd31) begin
                n_err++;
                $display("FAIL bypass port%0d: got %0d, expected 31", r, rd_data[r*DW +: DW]);
            end
        end
    endtask

    task automatic test_port_priority();
        idle();
        wr_en   = 2'b11;
        wr_addr = {5'd9, 5'd9};
        wr_data = {32'd200, 32'd100};
        rd_addr = {5'd9, 5'd3};
        tick();
        n_vec++;
        if (rd_data[1*DW +: DW] !== 32'd200) begin
            n_err++;
            $display("FAIL prio_bypass: got %0d, expected 200", rd_data[1*DW +: DW]);
        end
        idle();
        rd_addr = {5'd3, 5'd9};
        tick();
        n_vec++;
        if (rd_data[0 +: DW] !== 32'd200) begin
            n_err++;
            $display("FAIL prio_stored: got %0d, expected 200", rd_data[0 +: DW]);
        end
    endtask

    task automatic test_zero_reg();
        idle();
        wr_en = 2'b11;
        wr_addr = {5'd0, 5'd0};
        wr_data = {32'd55, 32'd55};
        resv_en = 1'b1; resv_addr = 5'd0;
        rd_addr = {5'd0, 5'd0};
        tick();
        idle();
        tick();
        for (int r = 0; r < NR; r++) begin
            n_vec++;
            if (rd_data[r*DW +: DW] !== 32'd0 || rd_pend[r] !== 1'b0) begin
                n_err++;
                $display("FAIL zero_reg port%0d: data=%0d pend=%b, expected 0/0", r, rd_data[r*DW +: DW], rd_pend[r]);
            end
        end
    endtask

    task automatic test_pending();
        idle();
        resv_en = 1'b1; resv_addr = 5'd7;
        rd_addr = {5'd2, 5'd7};
        tick();
        n_vec++;
        if (rd_pend !== 2'b01) begin
            n_err++;
            $display("FAIL pend_set: rd_pend=%b, expected 01", rd_pend);
        end
        idle();
        wr_en = 2'b10; wr_addr[1*AW +: AW] = 5'd7; wr_data[1*DW +: DW] = 32'hCAFE;
        tick();
        n_vec++;
        if (rd_pend !== 2'b00 || rd_data[0 +: DW] !== 32'hCAFE) begin
            n_err++;
            $display("FAIL pend_clear: rd_pend=%b data=%h, expected 00/cafe", rd_pend, rd_data[0 +: DW]);
        end
        resv_en = 1'b1; resv_addr = 5'd7;
        wr_en = 2'b01; wr_addr[0 +: AW] = 5'd7; wr_data[0 +: DW] = 32'hBEEF;
        tick();
        n_vec++;
        if (rd_pend !== 2'b01 || rd_data[0 +: DW] !== 32'hBEEF) begin
            n_err++;
            $display("FAIL pend_set_wins: rd_pend=%b data=%h, expected 01/beef", rd_pend, rd_data[0 +: DW]);
        end
        idle();
        tick();
        n_vec++;
        if (rd_pend !== 2'b01) begin
            n_err++;
            $display("FAIL pend_hold: rd_pend=%b, expected 01", rd_pend);
        end
    endtask

    task automatic test_reset_priority();
        idle();
        wr_en = 2'b01; wr_addr[0 +: AW] = 5'd1; wr_data[0 +: DW] = 32'd20;
        resv_en = 1'b1; resv_addr = 5'd3;
        rd_addr = {5'd3, 5'd1};
        tick();
        n_vec++;
        if (rd_data[0 +: DW] !== 32'd20 || rd_pend !== 2'b10) begin
            n_err++;
            $display("FAIL pre_reset: data=%0d pend=%b, expected 20/10", rd_data[0 +: DW], rd_pend);
        end
        reset = 1'b1;
        wr_en = 2'b11; wr_addr = {5'd1, 5'd3}; wr_data = {32'd77, 32'd88};
        resv_en = 1'b1; resv_addr = 5'd1;
        tick();
        n_vec++;
        if (rd_data !== '0 || rd_pend !== '0) begin
            n_err++;
            $display("FAIL reset_cycle_out: data=%h pend=%b, expected 0/00", rd_data, rd_pend);
        end
        idle();
        tick();
        n_vec++;
        if (rd_data !== {32'd3, 32'd1} || rd_pend !== 2'b00) begin
            n_err++;
            $display("FAIL post_reset: data=%h pend=%b, expected %h/00", rd_data, rd_pend, {32'd3, 32'd1});
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset   = ($urandom_range(0, 49) == 0);
            wr_en   = 2'($urandom_range(0, 3));
            resv_en = ($urandom_range(0, 3) == 0);
            // Small address range so collisions, bypass and set/clear races occur often.
            for (int p = 0; p < 2; p++) begin
                wr_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
                wr_data[p*DW +: DW] = $urandom;
            end
            resv_addr = AW'($urandom_range(0, 7));
            for (int r = 0; r < NR; r++) begin
                rd_addr[r*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31))
                                                                  : AW'($urandom_range(0, 7));
            end
            tick();
            for (int r = 0; r < NR; r++) begin
                n_vec++;
                if (rd_data[r*DW +: DW] !== e_dat[r] || rd_pend[r] !== e_pend[r]) begin
                    n_err++;
                    $display("FAIL random c%0d port%0d: data=%h pend=%b, expected %h/%b",
                             c, r, rd_data[r*DW +: DW], rd_pend[r], e_dat[r], e_pend[r]);
                end
            end
        end
        idle();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_write_bypass();
        test_port_priority();
        test_zero_reg();
        test_pending();
        test_reset_priority();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The block SHALL take parameter ADDR_W, default 5, meaning address width; depth = 2**ADDR_W.
REQ-003 The block SHALL take parameter NUM_RD, default 2, legal 1..4, meaning number of read ports.
REQ-004 The block SHALL take parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when 1.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port wr_en, input, 2 bits: per-write-port enable.
REQ-008 The block SHALL have port wr_addr, input, 2*ADDR_W bits: write addresses, port p in slice p.
REQ-009 The block SHALL have port wr_data, input, 2*DATA_W bits: write data, port p in slice p.
REQ-010 The block SHALL have port rd_addr, input, NUM_RD*ADDR_W bits: read addresses, port r in slice r.
REQ-011 The block SHALL have port rd_data, output, NUM_RD*DATA_W bits: registered read data.
REQ-012 The block SHALL have port resv_en, input, 1 bit: reserve request (marks a register as awaiting a write).
REQ-013 The block SHALL have port resv_addr, input, ADDR_W bits: register to reserve.
REQ-014 The block SHALL have port rd_pend, output, NUM_RD bits: registered pending flag for each read address.

Function
REQ-015 A write with wr_en[p]=1 SHALL update mem[wr_addr[p]] with wr_data[p] at the rising edge.
REQ-016 If both write ports target the same address in one cycle, port 1 SHALL win.
REQ-017 rd_data[r] SHALL be registered with 1-cycle latency: after edge N it holds the post-edge-N value of mem[rd_addr[r]] as sampled before edge N.
REQ-018 A read and write to the same address in the same cycle SHALL return the new write data (write-through bypass, port-1 priority applied).
REQ-019 With ZERO_REG=1, writes to address 0 SHALL be ignored, reads of address 0 SHALL return 0, and address 0 SHALL never be pending.
REQ-020 resv_en=1 SHALL set pending[resv_addr] at the rising edge.
REQ-021 A write on either port SHALL clear pending[wr_addr[p]] at the rising edge.
REQ-022 A reserve and a write to the same address in the same cycle SHALL leave the register pending (set wins; new producer).
REQ-023 rd_pend[r] SHALL be registered alongside rd_data[r] and reflect the post-edge pending state of rd_addr[r], including same-cycle set/clear.
REQ-024 No combinational path SHALL exist from any input to rd_data or rd_pend.

Reset
REQ-025 While reset=1 at a rising edge, mem[i] SHALL load value i (zero-extended) for every i, except mem[0]=0.
REQ-026 While reset=1 at a rising edge, rd_data SHALL load 0, rd_pend SHALL load 0, and all pending bits SHALL clear.
REQ-027 Reset SHALL take priority over simultaneous writes and reserves; inputs in that cycle SHALL be discarded.

Structure
REQ-028 The default widths, NUM_RD limits and the per-port slicing helpers SHALL live in the shared processor package.
REQ-029 One sub-module, reg_file_rd_port (address mux, bypass and output register for one read port), SHALL be instantiated NUM_RD times via generate.

Verification
REQ-030 Reset, then rd_addr={8,6} -> after one edge rd_data={8,6}, rd_pend=0.
REQ-031 wr_en=01, wr_addr[0]=4, wr_data[0]=31, rd_addr[0]=4 same cycle -> next edge rd_data[0]=31.
REQ-032 wr_en=11, both addr 9, data 100/200 -> subsequent read of 9 returns 200.
REQ-033 Write 55 to address 0, read address 0 -> rd_data=0; resv_addr=0 -> rd_pend=0.
REQ-034 resv 7 -> rd_pend=1 for addr 7; write 7 -> rd_pend=0; resv 7 and write 7 same cycle -> rd_pend=1.
REQ-035 Write 20 to addr 1 and resv 3, then assert reset -> read addr 1 returns 1, addr 3 rd_pend=0, rd_data during reset cycle output=0.
